// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, frame constants and the
// parity helper used by both the transmit and receive paths.
package uart_pkg;

  // Data bits per frame; fixed so that every frame matches the receiver.
  localparam int DATA_BITS = 8;

  // Widths of the per-bit baud counter and the bit-within-field counter.
  localparam int BAUD_W    = 12;
  localparam int BIT_CNT_W = 4;

  // Stop-bit selection encodings.
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Transmit frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // parity_sel=1 gives the XOR of the data bits, parity_sel=0 its inverse.
  function automatic logic uart_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 parity_sel);
    return parity_sel ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a producer and the UART transmit stage.
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 ready_out;

  // Producer side: offers bytes and watches ready.
  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  // Transmitter side: accepts bytes when it has room.
  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk cycles within one bit and flags the last one.
// clear holds the count at zero while the line is idle; start restarts the
// count at the beginning of a new frame.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [BAUD_W-1:0] divisor,
  output logic              bit_end
);

  logic [BAUD_W-1:0] count_reg;

  // divisor is never zero here; the caller substitutes 1 for 0.
  assign bit_end = !clear && (count_reg == (divisor - BAUD_W'(1)));

  // Cycle counter that wraps at the end of every bit period.
  always_ff @(posedge clk) begin
    if (reset || clear || start) begin
      count_reg <= '0;
    end else if (bit_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit stage: start bit, 8 data bits LSB first, parity, 1 or 2 stop
// bits. A one-entry holding register lets the next byte wait while the
// current frame is on the line, so consecutive frames have no idle gap.
module uart_tx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_en,
  input  logic                   parity_sel,
  input  logic                   stop_sel,
  input  logic [11:0]            baud_divisor,
  uart_tx_frame_if.slave         bus,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);
  import uart_pkg::*;

  tx_state_t                state_reg;
  logic [DATA_BITS-1:0]     shift_reg;
  logic [DATA_BITS-1:0]     hold_data_reg;
  logic                     hold_full_reg;
  logic                     parity_reg;
  logic                     stop_two_reg;
  logic                     tx_reg;
  logic [BIT_CNT_W-1:0]     bit_cnt_reg;
  logic [BAUD_W-1:0]        div_reg;

  logic [BAUD_W-1:0]        eff_div;
  logic                     capture;
  logic                     load;
  logic                     bit_end;
  logic                     last_stop;
  logic                     frame_end;

  // A divisor of zero would never produce a bit end, so run it as one.
  assign eff_div = (baud_divisor == '0) ? BAUD_W'(1) : baud_divisor;

  // Ready depends only on registered state and the enable, never on valid.
  assign bus.ready_out = tx_en && !hold_full_reg && !reset;
  assign capture       = bus.valid_in && bus.ready_out;

  // The final stop bit is the only one with one stop bit, the second with two.
  assign last_stop = (stop_two_reg == STOP_ONE) || (bit_cnt_reg == BIT_CNT_W'(1));
  assign frame_end = (state_reg == STOP) && bit_end && last_stop;

  // A new frame starts from idle, or straight out of the last stop bit.
  assign load = hold_full_reg && ((state_reg == IDLE) || frame_end);

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE) || hold_full_reg;
  assign frame_done = frame_end;

  uart_baud_gen u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg == IDLE),
    .start   (load),
    .divisor (div_reg),
    .bit_end (bit_end)
  );

  // Holding register: capture from the producer, empty when the FSM loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else begin
      if (capture) begin
        hold_data_reg <= bus.data_in;
        hold_full_reg <= 1'b1;
      end else if (load) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  // Frame sequencer with registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      stop_two_reg <= STOP_ONE;
      div_reg      <= BAUD_W'(1);
      bit_cnt_reg  <= '0;
      tx_reg       <= 1'b1;
    end else if (load) begin
      // Frame settings are frozen here and ignored until the next load.
      shift_reg    <= hold_data_reg;
      parity_reg   <= uart_parity(hold_data_reg, parity_sel);
      stop_two_reg <= stop_sel;
      div_reg      <= eff_div;
      bit_cnt_reg  <= '0;
      tx_reg       <= 1'b0;
      state_reg    <= START;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            tx_reg      <= shift_reg[0];
            bit_cnt_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_reg == BIT_CNT_W'(DATA_BITS - 1)) begin
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
            end else begin
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_reg      <= 1'b1;
            bit_cnt_reg <= '0;
            state_reg   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: a table of single frames with
// hand-computed line patterns, plus sequences for back-to-back frames,
// mid-frame configuration change, enable gating and reset mid-frame.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_en;
  logic        parity_sel;
  logic        stop_sel;
  logic [11:0] baud_divisor;
  logic        tx;
  logic        busy;
  logic        frame_done;

  uart_tx_frame_if bus ();

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .baud_divisor (baud_divisor),
    .bus          (bus),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  int tests = 0;
  int fails = 0;

  // seq holds the line bits in transmission order, first bit at [11].
  typedef struct {
    logic [7:0]  data;
    logic [11:0] div;
    logic        par;
    logic        stp;
    logic [11:0] seq;
    int          nbits;
    int          d;
  } vec_t;

  vec_t vecs[6];
  logic exp_tx[$];
  logic exp_done[$];
  logic got_rdy[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_frame(input logic [11:0] seq, input int nbits, input int d);
    logic [11:0] s;
    s = seq;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < d; c++) begin
        exp_tx.push_back(s[11-i]);
        exp_done.push_back((i == nbits - 1) && (c == d - 1));
      end
    end
  endtask

  // Hand over one byte; returns one cycle into the start bit.
  task automatic send_byte(input logic [7:0] b, input bit keep_valid, input string name);
    int n;
    n = 0;
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    while (!bus.ready_out && n < 200) begin
      step();
      n++;
    end
    if (!bus.ready_out) begin
      tests++;
      fails++;
      $display("FAIL %s handshake: ready_out stayed 0, required 1", name);
    end
    step();
    if (!keep_valid) bus.valid_in = 1'b0;
    chk({name, " tx before start"}, {31'd0, tx}, 32'd1);
    chk({name, " busy after capture"}, {31'd0, busy}, 32'd1);
    step();
    chk({name, " start latency tx"}, {31'd0, tx}, 32'd0);
  endtask

  // Sample tx/frame_done each cycle against the expected queues.
  task automatic check_wave(input string name);
    int etx;
    int edone;
    etx   = 0;
    edone = 0;
    got_rdy.delete();
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i > 0) begin
        step();
        if (i == 1) bus.valid_in = 1'b0;
      end
      if (tx !== exp_tx[i]) etx++;
      if (frame_done !== exp_done[i]) edone++;
      got_rdy.push_back(bus.ready_out);
    end
    chk({name, " tx wrong cycles"}, etx, 32'd0);
    chk({name, " frame_done wrong cycles"}, edone, 32'd0);
    step();
    chk({name, " idle tx"}, {31'd0, tx}, 32'd1);
    chk({name, " idle busy"}, {31'd0, busy}, 32'd0);
    exp_tx.delete();
    exp_done.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, div: 12'd4, par: 1'b1, stp: 1'b0, seq: 12'b0101_0010_1010, nbits: 11, d: 4};
    vecs[1] = '{data: 8'h01, div: 12'd2, par: 1'b0, stp: 1'b1, seq: 12'b0100_0000_0011, nbits: 12, d: 2};
    vecs[2] = '{data: 8'hFF, div: 12'd1, par: 1'b1, stp: 1'b1, seq: 12'b0111_1111_1011, nbits: 12, d: 1};
    vecs[3] = '{data: 8'h00, div: 12'd0, par: 1'b0, stp: 1'b0, seq: 12'b0000_0000_0110, nbits: 11, d: 1};
    vecs[4] = '{data: 8'h80, div: 12'd3, par: 1'b1, stp: 1'b0, seq: 12'b0000_0000_1110, nbits: 11, d: 3};
    vecs[5] = '{data: 8'h6B, div: 12'd5, par: 1'b0, stp: 1'b1, seq: 12'b0110_1011_0011, nbits: 12, d: 5};

    reset        = 1'b1;
    tx_en        = 1'b1;
    parity_sel   = 1'b1;
    stop_sel     = 1'b0;
    baud_divisor = 12'd4;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;

    // Reset state
    step(); step(); step();
    chk("reset ready_out low", {31'd0, bus.ready_out}, 32'd0);
    chk("reset tx high", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    #1;
    chk("post-reset ready_out", {31'd0, bus.ready_out}, 32'd1);
    chk("post-reset busy", {31'd0, busy}, 32'd0);
    chk("post-reset frame_done", {31'd0, frame_done}, 32'd0);

    // Table of single frames
    for (int k = 0; k < 6; k++) begin
      baud_divisor = vecs[k].div;
      parity_sel   = vecs[k].par;
      stop_sel     = vecs[k].stp;
      send_byte(vecs[k].data, 1'b0, $sformatf("vec%0d", k));
      add_frame(vecs[k].seq, vecs[k].nbits, vecs[k].d);
      check_wave($sformatf("vec%0d", k));
    end

    // tx_en low blocks captures
    tx_en        = 1'b0;
    bus.data_in  = 8'h12;
    bus.valid_in = 1'b1;
    #1;
    chk("tx_en low ready_out", {31'd0, bus.ready_out}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("tx_en low busy", {31'd0, busy}, 32'd0);
    chk("tx_en low tx", {31'd0, tx}, 32'd1);
    bus.valid_in = 1'b0;
    tx_en        = 1'b1;
    step();

    // Back-to-back frames with valid held high
    baud_divisor = 12'd2;
    parity_sel   = 1'b1;
    stop_sel     = 1'b0;
    send_byte(8'h55, 1'b1, "b2b first");
    bus.data_in = 8'hC3;
    add_frame(12'b0101_0101_0010, 11, 2);
    add_frame(12'b0110_0001_1010, 11, 2);
    check_wave("b2b");
    chk("b2b ready after first load", {31'd0, got_rdy[0]}, 32'd1);
    chk("b2b ready with hold full", {31'd0, got_rdy[1]}, 32'd0);
    chk("b2b ready at last stop cycle", {31'd0, got_rdy[21]}, 32'd0);
    chk("b2b ready after second load", {31'd0, got_rdy[22]}, 32'd1);

    // Divisor change mid-frame applies to the next frame only
    baud_divisor = 12'd4;
    send_byte(8'h0F, 1'b1, "midcfg first");
    baud_divisor = 12'd8;
    bus.data_in  = 8'hF0;
    add_frame(12'b0111_1000_0010, 11, 4);
    add_frame(12'b0000_0111_1010, 11, 8);
    check_wave("midcfg");

    // Reset during the third data bit at divisor 0
    baud_divisor = 12'd0;
    parity_sel   = 1'b1;
    stop_sel     = 1'b0;
    send_byte(8'hA5, 1'b0, "rst frame");
    step(); step(); step();
    chk("rst 3rd data bit on line", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    step();
    chk("rst tx next cycle", {31'd0, tx}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst ready during reset", {31'd0, bus.ready_out}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst ready follows tx_en=1", {31'd0, bus.ready_out}, 32'd1);
    tx_en = 1'b0;
    #1;
    chk("rst ready follows tx_en=0", {31'd0, bus.ready_out}, 32'd0);
    tx_en = 1'b1;
    step();
    chk("rst line idle before resend", {31'd0, tx}, 32'd1);
    send_byte(8'h3C, 1'b0, "rst resend");
    add_frame(12'b0001_1110_0010, 11, 1);
    check_wave("rst resend");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
